// File: rtl/dma_sched_pkg.sv
// Shared types for the DMA descriptor scheduler: FSM state encoding and the queued descriptor.
// Field widths here set the descriptor layout; the top-level ADDR_W/LEN_W defaults track them.
package dma_sched_pkg;

  localparam int DMA_ADDR_W = 28;
  localparam int DMA_LEN_W  = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    FINISH,
    ERROR
  } state_e;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  len;
    logic                  irq;
  } desc_t;

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor queue: DEPTH-entry synchronous FIFO, write-to-read latency one cycle, head shown combinationally.
// Push is refused when full (no same-cycle pop bypass); flush empties it and overrides push and pop.
module dma_desc_fifo
  import dma_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  desc_t                  wr_dat,
  input  logic                   pop,
  input  logic                   flush,
  output desc_t                  rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  desc_t       mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q[AW-1:0]];
  assign level  = wr_ptr_q - rd_ptr_q;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/dma_sched.sv
// Pops descriptors and issues them to the copy engine in MAX_CHUNK pieces; first start 3 cycles after push.
// desc_ready is !full from registered occupancy; the engine is never sent a new chunk before eng_done.
module dma_sched
  import dma_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = DMA_ADDR_W,
  parameter int LEN_W     = DMA_LEN_W,
  parameter int MAX_CHUNK = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [ADDR_W-1:0]      desc_src,
  input  logic [ADDR_W-1:0]      desc_dst,
  input  logic [LEN_W-1:0]       desc_len,
  input  logic                   desc_irq,
  output logic                   eng_start,
  output logic [ADDR_W-1:0]      eng_src,
  output logic [ADDR_W-1:0]      eng_dst,
  output logic [LEN_W-1:0]       eng_len,
  input  logic                   eng_done,
  input  logic                   eng_err,
  input  logic                   abort,
  input  logic                   err_clear,
  output logic                   busy,
  output logic                   err,
  output logic                   irq_done,
  output logic [15:0]            done_count,
  output logic [$clog2(DEPTH):0] queue_level
);

  localparam logic [LEN_W-1:0] CHUNK = LEN_W'(MAX_CHUNK);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                irq_q, irq_d;
  logic                abort_q, abort_d;
  logic [ADDR_W-1:0]   eng_src_q, eng_src_d;
  logic [ADDR_W-1:0]   eng_dst_q, eng_dst_d;
  logic [LEN_W-1:0]    eng_len_q, eng_len_d;
  logic [15:0]         done_count_q, done_count_d;

  desc_t               push_dat;
  desc_t               head;
  logic                fifo_pop;
  logic                fifo_flush;
  logic                fifo_full;
  logic                fifo_empty;

  assign push_dat = '{src: desc_src, dst: desc_dst, len: desc_len, irq: desc_irq};

  dma_desc_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (desc_valid),
    .wr_dat (push_dat),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (queue_level)
  );

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rem_d        = rem_q;
    irq_d        = irq_q;
    abort_d      = abort_q;
    eng_src_d    = eng_src_q;
    eng_dst_d    = eng_dst_q;
    eng_len_d    = eng_len_q;
    done_count_d = done_count_q;
    fifo_pop     = 1'b0;
    fifo_flush   = abort;

    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (!abort && !fifo_empty) begin
          fifo_pop = 1'b1;
          src_d    = head.src;
          dst_d    = head.dst;
          rem_d    = head.len;
          irq_d    = head.irq;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (abort)              state_d = IDLE;
        else if (rem_q == '0)   state_d = FINISH;
        else                    state_d = ISSUE;
      end
      ISSUE: begin
        // The strobe for this cycle is already out, so an abort here waits for its eng_done.
        if (abort) abort_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (abort) abort_d = 1'b1;
        if (eng_done) begin
          if (abort_q || abort) begin
            state_d = IDLE;
          end else if (eng_err) begin
            fifo_flush = 1'b1;
            state_d    = ERROR;
          end else begin
            src_d   = src_q + ADDR_W'(eng_len_q);
            dst_d   = dst_q + ADDR_W'(eng_len_q);
            rem_d   = rem_q - eng_len_q;
            state_d = (rem_d == '0) ? FINISH : ISSUE;
          end
        end
      end
      FINISH: state_d = IDLE;
      ERROR: begin
        if (err_clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Engine command registers load on the way into ISSUE so they are valid with the strobe.
    if (state_d == ISSUE) begin
      eng_src_d = src_d;
      eng_dst_d = dst_d;
      eng_len_d = (rem_d > CHUNK) ? CHUNK : rem_d;
    end
    if (state_d == FINISH) done_count_d = done_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      irq_q        <= 1'b0;
      abort_q      <= 1'b0;
      eng_src_q    <= '0;
      eng_dst_q    <= '0;
      eng_len_q    <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rem_q        <= rem_d;
      irq_q        <= irq_d;
      abort_q      <= abort_d;
      eng_src_q    <= eng_src_d;
      eng_dst_q    <= eng_dst_d;
      eng_len_q    <= eng_len_d;
      done_count_q <= done_count_d;
    end
  end

  assign desc_ready = !fifo_full;
  assign eng_start  = (state_q == ISSUE);
  assign eng_src    = eng_src_q;
  assign eng_dst    = eng_dst_q;
  assign eng_len    = eng_len_q;
  assign busy       = (state_q != IDLE);
  assign err        = (state_q == ERROR);
  assign irq_done   = (state_q == FINISH) && irq_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_dma_sched.sv
// Directed bench for dma_sched: drives descriptors and a hand-played engine, checks against hand-computed values.
module tb_dma_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [27:0] desc_src;
  logic [27:0] desc_dst;
  logic [23:0] desc_len;
  logic        desc_irq;
  logic        eng_start;
  logic [27:0] eng_src;
  logic [27:0] eng_dst;
  logic [23:0] eng_len;
  logic        eng_done;
  logic        eng_err;
  logic        abort;
  logic        err_clear;
  logic        busy;
  logic        err;
  logic        irq_done;
  logic [15:0] done_count;
  logic [2:0]  queue_level;

  int n_chk = 0;
  int n_err = 0;
  int start_cnt = 0;
  int irq_cnt = 0;

  always #5 clk = ~clk;

  dma_sched #(
    .DEPTH(4), .ADDR_W(28), .LEN_W(24), .MAX_CHUNK(256)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len), .desc_irq(desc_irq),
    .eng_start(eng_start), .eng_src(eng_src), .eng_dst(eng_dst), .eng_len(eng_len),
    .eng_done(eng_done), .eng_err(eng_err),
    .abort(abort), .err_clear(err_clear),
    .busy(busy), .err(err), .irq_done(irq_done),
    .done_count(done_count), .queue_level(queue_level)
  );

  always @(negedge clk) begin
    if (eng_start === 1'b1) start_cnt++;
    if (irq_done === 1'b1)  irq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [27:0] s, input logic [27:0] d, input logic [23:0] l, input logic i);
    int k;
    k = 0;
    desc_valid = 1'b1;
    desc_src   = s;
    desc_dst   = d;
    desc_len   = l;
    desc_irq   = i;
    while (desc_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("push_ready", 32'(desc_ready), 1);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic expect_start(input string tag, input logic [27:0] s, input logic [27:0] d,
                              input logic [23:0] l);
    int k;
    k = 0;
    while (eng_start !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_start"}, 32'(eng_start), 1);
    chk({tag, "_src"}, 32'(eng_src), 32'(s));
    chk({tag, "_dst"}, 32'(eng_dst), 32'(d));
    chk({tag, "_len"}, 32'(eng_len), 32'(l));
  endtask

  task automatic done(input logic e);
    eng_done = 1'b1;
    eng_err  = e;
    tick();
    eng_done = 1'b0;
    eng_err  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(desc_ready), 1);
    chk({tag, "_start"}, 32'(eng_start), 0);
    chk({tag, "_src"}, 32'(eng_src), 0);
    chk({tag, "_dst"}, 32'(eng_dst), 0);
    chk({tag, "_len"}, 32'(eng_len), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_irq"}, 32'(irq_done), 0);
    chk({tag, "_count"}, 32'(done_count), 0);
    chk({tag, "_level"}, 32'(queue_level), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int dc;
    int s0;
    int i0;
    rst_n = 1'b0; desc_valid = 1'b0; desc_src = '0; desc_dst = '0; desc_len = '0; desc_irq = 1'b0;
    eng_done = 1'b0; eng_err = 1'b0; abort = 1'b0; err_clear = 1'b0;
    tick(); tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single descriptor, cycle-exact latency.
    desc_valid = 1'b1; desc_src = 28'h0; desc_dst = 28'h100; desc_len = 24'h40; desc_irq = 1'b1;
    chk("t1_ready_n", 32'(desc_ready), 1);
    tick(); desc_valid = 1'b0;
    chk("t1_level_n1", 32'(queue_level), 1);
    chk("t1_busy_n1", 32'(busy), 0);
    tick();
    chk("t1_busy_n2", 32'(busy), 1);
    chk("t1_nostart_n2", 32'(eng_start), 0);
    chk("t1_level_n2", 32'(queue_level), 0);
    tick();
    chk("t1_start_n3", 32'(eng_start), 1);
    chk("t1_src", 32'(eng_src), 32'h0);
    chk("t1_dst", 32'(eng_dst), 32'h100);
    chk("t1_len", 32'(eng_len), 32'h40);
    tick();
    chk("t1_start_pulse", 32'(eng_start), 0);
    chk("t1_len_held", 32'(eng_len), 32'h40);
    tick();
    done(1'b0);
    chk("t1_irq_m1", 32'(irq_done), 1);
    chk("t1_count_m1", 32'(done_count), 1);
    tick();
    chk("t1_irq_pulse", 32'(irq_done), 0);
    chk("t1_idle", 32'(busy), 0);

    // Three-chunk descriptor with single-cycle chunk turnaround.
    i0 = irq_cnt;
    push(28'h0, 28'h1000, 24'h250, 1'b1);
    expect_start("t2c1", 28'h0, 28'h1000, 24'h100);
    tick(); done(1'b0);
    chk("t2_turnaround", 32'(eng_start), 1);
    expect_start("t2c2", 28'h100, 28'h1100, 24'h100);
    tick(); done(1'b0);
    expect_start("t2c3", 28'h200, 28'h1200, 24'h50);
    tick(); done(1'b0);
    chk("t2_irq", 32'(irq_done), 1);
    chk("t2_count", 32'(done_count), 2);
    tick(); tick();
    chk("t2_one_irq", 32'(irq_cnt - i0), 1);

    // Fill the queue behind a stalled engine; a push while full waits for desc_ready.
    dc = int'(done_count);
    push(28'h1040, 28'h2040, 24'h10, 1'b0);
    expect_start("t3d1", 28'h1040, 28'h2040, 24'h10);
    tick();
    for (int k = 2; k <= 4; k++) push(28'(32'h1000 + k * 32'h40), 28'(32'h2000 + k * 32'h40), 24'h10, 1'b0);
    chk("t3_level3", 32'(queue_level), 3);
    chk("t3_ready3", 32'(desc_ready), 1);
    push(28'h1140, 28'h2140, 24'h10, 1'b0);
    chk("t3_level4", 32'(queue_level), 4);
    chk("t3_full", 32'(desc_ready), 0);
    desc_valid = 1'b1; desc_src = 28'h1180; desc_dst = 28'h2180; desc_len = 24'h10; desc_irq = 1'b0;
    tick(); tick();
    chk("t3_held", 32'(queue_level), 4);
    done(1'b0);
    tick();
    chk("t3_nobypass_ready", 32'(desc_ready), 0);
    chk("t3_nobypass_level", 32'(queue_level), 4);
    tick();
    chk("t3_ready_rise", 32'(desc_ready), 1);
    chk("t3_level_pop", 32'(queue_level), 3);
    tick(); desc_valid = 1'b0;
    chk("t3_level_refill", 32'(queue_level), 4);
    for (int k = 2; k <= 6; k++) begin
      expect_start("t3d", 28'(32'h1000 + k * 32'h40), 28'(32'h2000 + k * 32'h40), 24'h10);
      tick(); done(1'b0);
    end
    tick();
    chk("t3_count", 32'(done_count), 32'(dc + 6));

    // Zero-length descriptor completes without touching the engine.
    dc = int'(done_count); s0 = start_cnt;
    push(28'h0, 28'h0, 24'h0, 1'b1);
    tick(); tick();
    chk("t4_irq", 32'(irq_done), 1);
    chk("t4_count", 32'(done_count), 32'(dc + 1));
    tick(); tick();
    chk("t4_nostart", 32'(start_cnt - s0), 0);
    chk("t4_idle", 32'(busy), 0);

    // Engine error on chunk 2 of 3 with two descriptors queued behind it.
    push(28'h4000, 28'h8000, 24'h300, 1'b1);
    push(28'h5000, 28'h9000, 24'h20, 1'b1);
    push(28'h5100, 28'h9100, 24'h20, 1'b1);
    expect_start("t5c1", 28'h4000, 28'h8000, 24'h100);
    tick(); done(1'b0);
    expect_start("t5c2", 28'h4100, 28'h8100, 24'h100);
    tick(); done(1'b1);
    chk("t5_err", 32'(err), 1);
    chk("t5_flushed", 32'(queue_level), 0);
    chk("t5_busy", 32'(busy), 1);
    s0 = start_cnt;
    tick(); tick(); tick(); tick();
    chk("t5_nostart", 32'(start_cnt - s0), 0);
    chk("t5_err_sticky", 32'(err), 1);
    push(28'h6000, 28'h6800, 24'h20, 1'b0);
    chk("t5_push_in_err", 32'(queue_level), 1);
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("t5_err_clear", 32'(err), 0);
    chk("t5_idle", 32'(busy), 0);
    expect_start("t5d", 28'h6000, 28'h6800, 24'h20);
    tick(); done(1'b0); tick();

    // Abort while the engine is busy: wait for its done, then drop the descriptor silently.
    dc = int'(done_count); i0 = irq_cnt;
    push(28'h7000, 28'h7100, 24'h20, 1'b1);
    push(28'h7200, 28'h7300, 24'h20, 1'b1);
    expect_start("t6e", 28'h7000, 28'h7100, 24'h20);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_flushed", 32'(queue_level), 0);
    chk("t6_wait_busy", 32'(busy), 1);
    tick(); tick();
    done(1'b0);
    chk("t6_idle", 32'(busy), 0);
    chk("t6_no_irq", 32'(irq_done), 0);
    chk("t6_no_count", 32'(done_count), 32'(dc));
    tick(); tick();
    chk("t6_no_irq_later", 32'(irq_cnt - i0), 0);
    chk("t6_stays_idle", 32'(busy), 0);

    // Asynchronous reset in the middle of WAIT with a descriptor queued.
    push(28'h100, 28'h200, 24'h40, 1'b0);
    expect_start("t7g", 28'h100, 28'h200, 24'h40);
    tick();
    push(28'h300, 28'h400, 24'h40, 1'b0);
    chk("t7_queued", 32'(queue_level), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t7_rst");
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
